// File: rtl/power_converter_seq_if.sv
// Signal bundle between the sampling/control side and the power converter sequencer.
// The master side supplies the run request, reference, samples and fault acknowledge.
// The slave side (the sequencer) returns the duty word, enable, status flags and state.
interface power_converter_seq_if;
  logic       en;
  logic [7:0] vref;
  logic       sample_valid;
  logic [7:0] vin;
  logic [7:0] vout;
  logic       fault_clr;
  logic [7:0] duty;
  logic       conv_on;
  logic       ready;
  logic       fault_uv;
  logic       fault_ov;
  logic [2:0] state;

  modport master (
    output en, vref, sample_valid, vin, vout, fault_clr,
    input  duty, conv_on, ready, fault_uv, fault_ov, state
  );

  modport slave (
    input  en, vref, sample_valid, vin, vout, fault_clr,
    output duty, conv_on, ready, fault_uv, fault_ov, state
  );
endinterface

// File: rtl/power_converter_seq.sv
// Power converter sequencer/regulator.
// Soft-starts the duty word with a slow ramp, regulates duty toward vref with a
// deadband while running, ramps down when the run request drops, and latches
// under/over-voltage faults until they are acknowledged with the converter idle.
// Every output is a register; decisions made on this cycle's inputs show up at
// the next clock edge. rst_n is an active-high synchronous reset.
module power_converter_seq #(
  parameter int RAMP_DIV    = 4,
  parameter int VIN_MIN     = 40,
  parameter int VOUT_MAX    = 240,
  parameter int DUTY_MAX    = 200,
  parameter int HYST        = 2,
  parameter int COOL_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  power_converter_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SOFTSTART = 3'd1,
    RUN       = 3'd2,
    RAMPDOWN  = 3'd3,
    FAULT     = 3'd4,
    COOLDOWN  = 3'd5
  } state_t;

  // A 1-clock ramp or cooldown still needs a 1-bit counter that simply stays at 0.
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int COOL_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'(COOL_CYCLES - 1);
  localparam logic [7:0]        VIN_MIN_L  = 8'(VIN_MIN);
  localparam logic [7:0]        VOUT_MAX_L = 8'(VOUT_MAX);
  localparam logic [7:0]        DUTY_MAX_L = 8'(DUTY_MAX);
  localparam logic [8:0]        HYST_L     = 9'(HYST);

  state_t              state_reg;
  logic [7:0]          duty_reg;
  logic                conv_on_reg;
  logic                ready_reg;
  logic                uv_reg;
  logic                ov_reg;
  logic [RAMP_W-1:0]   ramp_cnt;
  logic [COOL_W-1:0]   cool_cnt;

  logic [8:0] vout_ext;
  logic [8:0] vref_ext;
  logic       vin_low;
  logic       sample_uv;
  logic       sample_ov;
  logic       fault_hit;
  logic       ramp_tick;
  logic       reg_up;
  logic       reg_down;
  logic       run_reached;

  // Regulation compares are done one bit wider so vref+HYST and vout+HYST never wrap.
  assign vout_ext = {1'b0, bus.vout};
  assign vref_ext = {1'b0, bus.vref};

  assign vin_low     = bus.vin < VIN_MIN_L;
  assign sample_uv   = bus.sample_valid && vin_low;
  assign sample_ov   = bus.sample_valid && (bus.vout > VOUT_MAX_L);
  assign fault_hit   = sample_uv || sample_ov;
  assign ramp_tick   = ramp_cnt == RAMP_LAST;
  assign reg_up      = bus.sample_valid && ((vout_ext + HYST_L) < vref_ext);
  assign reg_down    = bus.sample_valid && (vout_ext > (vref_ext + HYST_L));
  assign run_reached = (bus.sample_valid && (bus.vout >= bus.vref)) || (duty_reg == DUTY_MAX_L);

  // Sequencer: state, duty word, enables, latched fault flags and the two timers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= IDLE;
      duty_reg    <= '0;
      conv_on_reg <= 1'b0;
      ready_reg   <= 1'b0;
      uv_reg      <= 1'b0;
      ov_reg      <= 1'b0;
      ramp_cnt    <= '0;
      cool_cnt    <= '0;
    end else begin
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
      case (state_reg)
        IDLE: begin
          duty_reg    <= '0;
          conv_on_reg <= 1'b0;
          ready_reg   <= 1'b0;
          if (bus.en && bus.sample_valid && !vin_low) begin
            state_reg   <= SOFTSTART;
            conv_on_reg <= 1'b1;
            ramp_cnt    <= '0;
          end
        end

        SOFTSTART: begin
          if (fault_hit) begin
            state_reg   <= FAULT;
            duty_reg    <= '0;
            conv_on_reg <= 1'b0;
            ready_reg   <= 1'b0;
            uv_reg      <= uv_reg || sample_uv;
            ov_reg      <= ov_reg || sample_ov;
            ramp_cnt    <= '0;
          end else if (!bus.en) begin
            state_reg <= RAMPDOWN;
            ramp_cnt  <= '0;
          end else if (run_reached) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
            ramp_cnt  <= '0;
          end else if (ramp_tick && (duty_reg < DUTY_MAX_L)) begin
            duty_reg <= duty_reg + 8'd1;
          end
        end

        RUN: begin
          if (fault_hit) begin
            state_reg   <= FAULT;
            duty_reg    <= '0;
            conv_on_reg <= 1'b0;
            ready_reg   <= 1'b0;
            uv_reg      <= uv_reg || sample_uv;
            ov_reg      <= ov_reg || sample_ov;
            ramp_cnt    <= '0;
          end else if (!bus.en) begin
            state_reg <= RAMPDOWN;
            ready_reg <= 1'b0;
            ramp_cnt  <= '0;
          end else if (reg_up) begin
            if (duty_reg < DUTY_MAX_L) begin
              duty_reg <= duty_reg + 8'd1;
            end
          end else if (reg_down) begin
            if (duty_reg != 8'd0) begin
              duty_reg <= duty_reg - 8'd1;
            end
          end
        end

        RAMPDOWN: begin
          if (fault_hit) begin
            state_reg   <= FAULT;
            duty_reg    <= '0;
            conv_on_reg <= 1'b0;
            ready_reg   <= 1'b0;
            uv_reg      <= uv_reg || sample_uv;
            ov_reg      <= ov_reg || sample_ov;
            ramp_cnt    <= '0;
          end else if (duty_reg == 8'd0) begin
            state_reg   <= IDLE;
            conv_on_reg <= 1'b0;
            ramp_cnt    <= '0;
          end else if (ramp_tick) begin
            duty_reg <= duty_reg - 8'd1;
          end
        end

        FAULT: begin
          duty_reg    <= '0;
          conv_on_reg <= 1'b0;
          ready_reg   <= 1'b0;
          if (bus.fault_clr && !bus.en) begin
            state_reg <= COOLDOWN;
            uv_reg    <= 1'b0;
            ov_reg    <= 1'b0;
            cool_cnt  <= '0;
            ramp_cnt  <= '0;
          end
        end

        COOLDOWN: begin
          duty_reg    <= '0;
          conv_on_reg <= 1'b0;
          ready_reg   <= 1'b0;
          if (cool_cnt == COOL_LAST) begin
            state_reg <= IDLE;
            cool_cnt  <= '0;
            ramp_cnt  <= '0;
          end else begin
            cool_cnt <= cool_cnt + 1'b1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          duty_reg    <= '0;
          conv_on_reg <= 1'b0;
          ready_reg   <= 1'b0;
          ramp_cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.duty     = duty_reg;
  assign bus.conv_on  = conv_on_reg;
  assign bus.ready    = ready_reg;
  assign bus.fault_uv = uv_reg;
  assign bus.fault_ov = ov_reg;
  assign bus.state    = state_reg;

endmodule
